mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one single-ported, synchronous-read unified memory between the CPU instruction-fetch port and the CPU load/store port.
- Sits between the cpu core (fetch on iaddr, load/store on daddr/din/dout/MemWrite) and a single RAM macro.
- Arbitrates on a per-cycle basis and returns read data or a write acknowledge one cycle after grant.
- Data accesses have priority; a streak counter bounds how long fetch can be starved.

Parameters:
- ADDR_W, 32, byte-address width of both requester ports
- DATA_W, 32, data width
- MEM_AW, 10, memory word-address width; m_addr = addr[MEM_AW+1:2]
- MAX_STREAK, 4, maximum consecutive data grants while a fetch is pending (range 1..15)

Ports:
- sys_clk  in  1  clock; all state changes on the rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held with i_addr stable until i_gnt
- i_addr  in  ADDR_W  fetch byte address
- i_gnt  out  1  combinational; fetch issued to memory this cycle
- i_valid  out  1  registered; i_rdata valid (cycle after i_gnt)
- i_rdata  out  DATA_W  = m_rdata
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  combinational; data access issued this cycle
- d_valid  out  1  registered; load data valid or store complete
- d_rdata  out  DATA_W  = m_rdata
- m_en  out  1  memory enable
- m_we  out  1  memory write enable
- m_addr  out  MEM_AW  memory word address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid the cycle after m_en

Behaviour:
- Reset (asynchronous):
  - i_valid = d_valid = 0.
  - Streak counter = 0.
  - In-flight flags (i_busy, d_busy) = 0.
- When no grant is issued: m_en = m_we = 0, m_addr = 0, m_wdata = 0.
- Eligibility:
  - I eligible = i_req & ~i_busy; D eligible = d_req & ~d_busy.
  - A port granted in cycle N is busy during cycle N+1, so the same request is never issued twice.
- Selection, each cycle:
  - Only one eligible: grant it.
  - Both eligible: grant D unless streak == MAX_STREAK, in which case grant I.
  - Exactly one of i_gnt/d_gnt may be high, and only if the corresponding req is high.
- Issue:
  - m_en = 1 on the granted port's address.
  - m_we = d_we & d_gnt; m_wdata = d_wdata when d_gnt.
  - The write takes effect at this clock edge.
- Response:
  - i_valid / d_valid equal i_gnt / d_gnt delayed one cycle.
  - i_busy = i_valid and d_busy = d_valid (same registers).
- Per-port throughput: at most one access per 2 cycles. Aggregate throughput: one access per cycle when ports alternate.
- Streak counter (4 bits):
  - +1 on a d_gnt while i_req is high and not granted.
  - Cleared on i_gnt, or on any cycle with i_req low.
  - Saturates at MAX_STREAK.
- FSM (registered last-grant state):
  - States: IDLE (nothing in flight), I_FLIGHT, D_FLIGHT.
  - Next state = I_FLIGHT on i_gnt, D_FLIGHT on d_gnt, else IDLE.
  - Valids are decoded from this state.
- Address bits [1:0] are ignored; misaligned accesses are silently word-aligned. Address bits above MEM_AW+1 are ignored (address wraps).
- Simultaneous events:
  - Response for one port and a new grant to the other port in the same cycle is legal and required.
  - A requester dropping req in its response cycle is legal.
  - A requester raising a new req in its response cycle is not eligible until the next cycle.
- Reset mid-operation: an in-flight response is discarded (no valid pulse). A store already granted has completed.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum arb_state_t {IDLE, I_FLIGHT, D_FLIGHT}.
  - typedef port_sel_t (NONE, PORT_I, PORT_D).
  - localparam STREAK_W = 4.
- One natural sub-module: arb_fair_sel. It is combinational priority/streak selection plus the streak counter register; the top level holds the FSM and muxes.

Test Plan:
1. Reset, then idle with no requests -> all outputs 0 for 5 cycles; m_en never 1.
2. i_req, i_addr=0x0000_0010, memory word 4 = 0x2402_0005 -> i_gnt in cycle 0, m_addr=4; cycle 1: i_valid=1, i_rdata=0x2402_0005; d_valid stays 0.
3. d_req store, d_addr=0x40, d_wdata=0xDEAD_BEEF, then load of 0x40 -> store: m_we=1, m_addr=0x10, d_valid next cycle; load returns 0xDEAD_BEEF one cycle after its grant.
4. i_req and d_req both held high continuously, MAX_STREAK=4 -> grant pattern over 10 cycles is D,I,D,I,…; fetch granted at least once every 5 cycles; i_gnt and d_gnt never high together.
5. d_req re-asserted every eligible cycle with i_req pending (d_busy alternation disabled via a back-to-back bench) -> exactly 4 D grants, then I grant, then counter = 0.
6. sys_rst_n pulsed low mid-cycle after i_gnt -> i_valid stays 0, asynchronous clear observed before the next edge; normal fetch resumes after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and constants for the memory arbiter.
//   - arb_state_t : last-grant state held by the top-level FSM
//   - port_sel_t  : per-cycle selection result from arb_fair_sel
//   - STREAK_W    : width of the data-grant streak counter
package mem_arb_pkg;

    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        I_FLIGHT = 2'd1,
        D_FLIGHT = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        PORT_I = 2'd1,
        PORT_D = 2'd2
    } port_sel_t;

endpackage

// File: rtl/mem_arbiter_arb_fair_sel.sv
// arb_fair_sel
//   Per-cycle grant selection between the fetch (I) and data (D) ports.
//   D wins ties unless D has already been granted MAX_STREAK times in a
//   row while a fetch was waiting, in which case I wins.
// Ports:
//   clk_i     in  clock
//   rst_ni    in  asynchronous active-low reset
//   i_req_i   in  raw fetch request (streak is only kept while it is high)
//   i_elig_i  in  fetch request eligible this cycle
//   d_elig_i  in  data request eligible this cycle
//   sel_o     out selected port (NONE, PORT_I, PORT_D)
module arb_fair_sel
    import mem_arb_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      i_req_i,
    input  logic      i_elig_i,
    input  logic      d_elig_i,
    output port_sel_t sel_o
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;

    always_comb begin
        sel_o = NONE;
        if (i_elig_i && d_elig_i) begin
            sel_o = (streak_q == STREAK_MAX) ? PORT_I : PORT_D;
        end else if (i_elig_i) begin
            sel_o = PORT_I;
        end else if (d_elig_i) begin
            sel_o = PORT_D;
        end

        // The streak only measures starvation of a fetch that is actually
        // waiting, so it resets as soon as the fetch is served or withdrawn.
        streak_d = streak_q;
        if (!i_req_i || (sel_o == PORT_I)) begin
            streak_d = '0;
        end else if ((sel_o == PORT_D) && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported synchronous-read RAM between the CPU fetch
//   port (I) and load/store port (D). One access is issued per cycle;
//   the response (read data or store acknowledge) appears one cycle later.
// Ports:
//   sys_clk, sys_rst_n          clock, asynchronous active-low reset
//   i_req/i_addr                fetch request and byte address
//   i_gnt/i_valid/i_rdata       fetch grant (comb), response valid, data
//   d_req/d_we/d_addr/d_wdata   data request, store flag, address, data
//   d_gnt/d_valid/d_rdata       data grant (comb), response valid, data
//   m_en/m_we/m_addr/m_wdata    RAM command (word address)
//   m_rdata                     RAM read data, valid the cycle after m_en
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_AW     = 10,
    parameter int MAX_STREAK = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [MEM_AW-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    arb_state_t state_q;
    arb_state_t state_d;
    port_sel_t  sel;
    logic       i_elig;
    logic       d_elig;

    // The response-valid registers double as the busy flags: a port that
    // was granted last cycle cannot be granted again this cycle.
    assign i_valid = (state_q == I_FLIGHT);
    assign d_valid = (state_q == D_FLIGHT);
    assign i_elig  = i_req & ~i_valid;
    assign d_elig  = d_req & ~d_valid;

    // The RAM output is shared; the valids say whose data it is.
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    // Byte-offset bits and bits above the RAM window are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[ADDR_W-1:MEM_AW+2], i_addr[1:0],
                                d_addr[ADDR_W-1:MEM_AW+2], d_addr[1:0]};

    arb_fair_sel #(
        .MAX_STREAK (MAX_STREAK)
    ) u_sel (
        .clk_i    (sys_clk),
        .rst_ni   (sys_rst_n),
        .i_req_i  (i_req),
        .i_elig_i (i_elig),
        .d_elig_i (d_elig),
        .sel_o    (sel)
    );

    always_comb begin
        i_gnt   = (sel == PORT_I);
        d_gnt   = (sel == PORT_D);
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        state_d = IDLE;
        if (i_gnt) begin
            m_en    = 1'b1;
            m_addr  = i_addr[MEM_AW+1:2];
            state_d = I_FLIGHT;
        end else if (d_gnt) begin
            m_en    = 1'b1;
            m_we    = d_we;
            m_addr  = d_addr[MEM_AW+1:2];
            m_wdata = d_wdata;
            state_d = D_FLIGHT;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
